// File: rtl/match_flow_ctrl_pkg.sv
// Shared game-mode encoding and on-screen button boxes for the match sequencer.
package match_flow_ctrl_pkg;

  // PAUSED keeps its code even when pausing is not built in.
  typedef enum logic [2:0] {
    START     = 3'd0,
    COUNTDOWN = 3'd1,
    GAME      = 3'd2,
    ROUND_END = 3'd3,
    MATCH_END = 3'd4,
    PAUSED    = 3'd5
  } game_mode;

  localparam logic [11:0] PLAY_X_MIN = 12'd16;
  localparam logic [11:0] PLAY_X_MAX = 12'd1007;
  localparam logic [11:0] PLAY_Y_MIN = 12'd400;
  localparam logic [11:0] PLAY_Y_MAX = 12'd479;

  localparam logic [11:0] RECT_X_MIN = 12'd400;
  localparam logic [11:0] RECT_X_MAX = 12'd623;
  localparam logic [11:0] RECT_Y_MIN = 12'd600;
  localparam logic [11:0] RECT_Y_MAX = 12'd679;

  function automatic logic in_box(input logic [11:0] x, input logic [11:0] y,
                                  input logic [11:0] xmin, input logic [11:0] xmax,
                                  input logic [11:0] ymin, input logic [11:0] ymax);
    return (x >= xmin) && (x <= xmax) && (y >= ymin) && (y <= ymax);
  endfunction

endpackage

// File: rtl/mouse_click_detect.sv
// Registers a mouse button level and emits a one-cycle pulse on its rising edge.
module mouse_click_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      btn_q <= btn;
      pulse <= btn & ~btn_q;
    end
  end

endmodule

// File: rtl/match_flow_ctrl.sv
// N-player match sequencer: lobby, countdown, rounds, scoring and winner screen.
// Optional right-button pause is built in when MATCH_FLOW_PAUSE_EN is defined.
//   state     | meaning
//   START     | lobby, waiting for a join click in the PLAY box
//   COUNTDOWN | pre-round countdown, count_left running down
//   GAME      | round in play, collisions knock players out
//   ROUND_END | result hold before next round or match end
//   MATCH_END | winner shown, RECT click returns to lobby
//   PAUSED    | round frozen (pause build only)
module match_flow_ctrl
  import match_flow_ctrl_pkg::*;
#(
  parameter int NUM_PLAYERS       = 2,
  parameter int WIN_ROUNDS        = 3,
  parameter int COUNTDOWN_CYCLES  = 65000000,
  parameter int ROUND_HOLD_CYCLES = 32500000,
  parameter int H_RES             = 1024
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            mouse_left,
  input  logic                                            mouse_right,
  input  logic [11:0]                                     xpos,
  input  logic [11:0]                                     ypos,
  input  logic [NUM_PLAYERS-1:0]                          collision,
  output game_mode                                        mode,
  output logic [NUM_PLAYERS-1:0]                          local_player,
  output logic [NUM_PLAYERS-1:0]                          alive,
  output logic [NUM_PLAYERS*$clog2(WIN_ROUNDS+1)-1:0]     score,
  output logic [31:0]                                     count_left,
  output logic [$clog2(NUM_PLAYERS)-1:0]                  winner_id,
  output logic                                            winner_valid
);

  localparam int SW = $clog2(WIN_ROUNDS+1);
  localparam int WW = $clog2(NUM_PLAYERS);
  localparam logic [SW-1:0] WIN_SW    = SW'(WIN_ROUNDS);
  localparam logic [31:0]   CD_LOAD   = 32'(COUNTDOWN_CYCLES - 1);
  localparam logic [31:0]   HOLD_LOAD = 32'(ROUND_HOLD_CYCLES - 1);

  function automatic logic [3:0] popcount(input logic [NUM_PLAYERS-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) popcount = popcount + 4'(v[i]);
  endfunction

  function automatic logic [WW-1:0] first_set(input logic [NUM_PLAYERS-1:0] v);
    first_set = '0;
    for (int i = NUM_PLAYERS-1; i >= 0; i--) if (v[i]) first_set = WW'(i);
  endfunction

  // Strip index is xpos*N/H_RES, found by threshold compares instead of a divider.
  function automatic logic [NUM_PLAYERS-1:0] strip_onehot(input logic [11:0] x);
    logic [31:0] xs;
    int          idx;
    xs  = 32'(x) * 32'(NUM_PLAYERS);
    idx = 0;
    for (int i = 1; i < NUM_PLAYERS; i++) if (xs >= 32'(i * H_RES)) idx = i;
    strip_onehot = NUM_PLAYERS'(1) << idx;
  endfunction

  game_mode                      state, state_nxt;
  logic                          click_l, click_r, pause_req;
  logic [NUM_PLAYERS-1:0]        local_nxt, alive_nxt, alive_hit, win_mask;
  logic [NUM_PLAYERS*SW-1:0]     score_nxt;
  logic [31:0]                   count_nxt, hold_cnt, hold_nxt;
  logic [WW-1:0]                 wid_nxt;
  logic                          wv_nxt;
  logic [3:0]                    hit_cnt;

  mouse_click_detect u_click_left (
    .clk   (clk),
    .rst   (rst),
    .btn   (mouse_left),
    .pulse (click_l)
  );

  mouse_click_detect u_click_right (
    .clk   (clk),
    .rst   (rst),
    .btn   (mouse_right),
    .pulse (click_r)
  );

`ifdef MATCH_FLOW_PAUSE_EN
  // A collision in the same cycle wins over the pause request.
  assign pause_req = click_r & ~(|collision);
`else
  logic unused_right;
  assign unused_right = click_r;
  assign pause_req    = 1'b0;
`endif

  assign mode      = state;
  assign alive_hit = alive & ~collision;
  assign hit_cnt   = popcount(alive_hit);

  always_comb begin
    win_mask = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) win_mask[i] = (score[i*SW +: SW] == WIN_SW);
  end

  always_comb begin
    state_nxt = state;
    local_nxt = local_player;
    alive_nxt = alive;
    score_nxt = score;
    count_nxt = count_left;
    hold_nxt  = hold_cnt;
    wid_nxt   = winner_id;
    wv_nxt    = winner_valid;
    case (state)
      START: begin
        if (click_l && in_box(xpos, ypos, PLAY_X_MIN, PLAY_X_MAX, PLAY_Y_MIN, PLAY_Y_MAX)) begin
          local_nxt = strip_onehot(xpos);
          score_nxt = '0;
          count_nxt = CD_LOAD;
          state_nxt = COUNTDOWN;
        end
      end
      COUNTDOWN: begin
        if (count_left == 32'd0) begin
          alive_nxt = '1;
          state_nxt = GAME;
        end else begin
          count_nxt = count_left - 32'd1;
        end
      end
      GAME: begin
        if (pause_req) begin
          state_nxt = PAUSED;
        end else begin
          alive_nxt = alive_hit;
          if (hit_cnt <= 4'd1) begin
            state_nxt = ROUND_END;
            hold_nxt  = HOLD_LOAD;
            if (hit_cnt == 4'd1) begin
              for (int i = 0; i < NUM_PLAYERS; i++)
                if (alive_hit[i] && score[i*SW +: SW] != WIN_SW)
                  score_nxt[i*SW +: SW] = score[i*SW +: SW] + SW'(1);
            end
          end
        end
      end
      ROUND_END: begin
        if (hold_cnt == 32'd0) begin
          if (|win_mask) begin
            wid_nxt   = first_set(win_mask);
            wv_nxt    = 1'b1;
            state_nxt = MATCH_END;
          end else begin
            count_nxt = CD_LOAD;
            state_nxt = COUNTDOWN;
          end
        end else begin
          hold_nxt = hold_cnt - 32'd1;
        end
      end
      MATCH_END: begin
        if (click_l && in_box(xpos, ypos, RECT_X_MIN, RECT_X_MAX, RECT_Y_MIN, RECT_Y_MAX)) begin
          local_nxt = '0;
          score_nxt = '0;
          alive_nxt = '0;
          wid_nxt   = '0;
          wv_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      PAUSED: begin
`ifdef MATCH_FLOW_PAUSE_EN
        if (click_r) state_nxt = GAME;
`else
        state_nxt = START;
`endif
      end
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= START;
      local_player <= '0;
      alive        <= '0;
      score        <= '0;
      count_left   <= '0;
      hold_cnt     <= '0;
      winner_id    <= '0;
      winner_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      local_player <= local_nxt;
      alive        <= alive_nxt;
      score        <= score_nxt;
      count_left   <= count_nxt;
      hold_cnt     <= hold_nxt;
      winner_id    <= wid_nxt;
      winner_valid <= wv_nxt;
    end
  end

endmodule

// File: tb/tb_match_flow_ctrl.sv
// Table-driven bench for match_flow_ctrl with a small expected-result queue.
module tb_match_flow_ctrl;
  import match_flow_ctrl_pkg::*;

  localparam int NP = 2;
  localparam int WR = 2;
  localparam int CD = 5;
  localparam int RH = 3;

  logic        clk = 1'b0;
  logic        rst, ml, mr;
  logic [11:0] xpos, ypos;
  logic [1:0]  coll;
  game_mode    mode;
  logic [1:0]  local_player, alive;
  logic [3:0]  score;
  logic [31:0] count_left;
  logic [0:0]  winner_id;
  logic        winner_valid;

  match_flow_ctrl #(
    .NUM_PLAYERS(NP), .WIN_ROUNDS(WR), .COUNTDOWN_CYCLES(CD),
    .ROUND_HOLD_CYCLES(RH), .H_RES(1024)
  ) dut (
    .clk(clk), .rst(rst), .mouse_left(ml), .mouse_right(mr),
    .xpos(xpos), .ypos(ypos), .collision(coll), .mode(mode),
    .local_player(local_player), .alive(alive), .score(score),
    .count_left(count_left), .winner_id(winner_id), .winner_valid(winner_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ml, mr;
    logic [11:0] x, y;
    logic [1:0]  coll;
    int          n;
    game_mode    e_mode;
    logic [1:0]  e_local, e_alive;
    logic [3:0]  e_score;
    logic [31:0] e_cl;
    logic        e_wid, e_wv;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   edges;

  function void add(input int r, input int m, input int mrr, input int x, input int y,
                    input int c, input int n, input game_mode em, input int el,
                    input int ea, input int es, input int ecl, input int ew, input int ev);
    vec_t v;
    v.rst = 1'(r); v.ml = 1'(m); v.mr = 1'(mrr);
    v.x = 12'(x); v.y = 12'(y); v.coll = 2'(c); v.n = n;
    v.e_mode = em; v.e_local = 2'(el); v.e_alive = 2'(ea); v.e_score = 4'(es);
    v.e_cl = 32'(ecl); v.e_wid = 1'(ew); v.e_wv = 1'(ev);
    vecs.push_back(v);
  endfunction

  task automatic check_vec(input vec_t e, input int k);
    n_total++;
    if (mode === e.e_mode && local_player === e.e_local && alive === e.e_alive &&
        score === e.e_score && count_left === e.e_cl && winner_id === e.e_wid &&
        winner_valid === e.e_wv)
      n_pass++;
    else
      $display("FAIL vec%0d: got mode=%s local=%b alive=%b score=%b cl=%0d wid=%0d wv=%b; want mode=%s local=%b alive=%b score=%b cl=%0d wid=%0d wv=%b",
               k, mode.name(), local_player, alive, score, count_left, winner_id, winner_valid,
               e.e_mode.name(), e.e_local, e.e_alive, e.e_score, e.e_cl, e.e_wid, e.e_wv);
  endtask

  task automatic check_val(input string nm, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  initial begin
    rst = 1'b1; ml = 1'b0; mr = 1'b0; xpos = '0; ypos = '0; coll = '0;

    //   r ml mr  x    y   coll n   mode       local alive score cl wid wv
    add(1, 0, 0, 0,   0,   0,  2, START,     0,    0,    0,    0, 0, 0);
    add(0, 1, 0, 800, 100, 0,  2, START,     0,    0,    0,    0, 0, 0);
    add(0, 0, 0, 800, 100, 0,  1, START,     0,    0,    0,    0, 0, 0);
    add(0, 1, 0, 800, 440, 0,  2, COUNTDOWN, 2,    0,    0,    4, 0, 0);
    add(0, 1, 0, 800, 440, 0,  2, COUNTDOWN, 2,    0,    0,    2, 0, 0);
    add(0, 1, 0, 800, 440, 0,  3, GAME,      2,    3,    0,    0, 0, 0);
    add(0, 1, 0, 800, 440, 0,  3, GAME,      2,    3,    0,    0, 0, 0);
    add(0, 0, 0, 800, 440, 1,  1, ROUND_END, 2,    2,    4,    0, 0, 0);
    add(0, 0, 0, 800, 440, 0,  2, ROUND_END, 2,    2,    4,    0, 0, 0);
    add(0, 0, 0, 800, 440, 0,  1, COUNTDOWN, 2,    2,    4,    4, 0, 0);
    add(0, 0, 0, 800, 440, 0,  5, GAME,      2,    3,    4,    0, 0, 0);
    add(0, 0, 0, 800, 440, 3,  1, ROUND_END, 2,    0,    4,    0, 0, 0);
    add(0, 0, 0, 800, 440, 0,  3, COUNTDOWN, 2,    0,    4,    4, 0, 0);
    add(0, 0, 0, 800, 440, 0,  5, GAME,      2,    3,    4,    0, 0, 0);
    add(0, 0, 0, 800, 440, 2,  1, ROUND_END, 2,    1,    5,    0, 0, 0);
    add(0, 0, 0, 800, 440, 0,  3, COUNTDOWN, 2,    1,    5,    4, 0, 0);
    add(0, 0, 0, 800, 440, 0,  5, GAME,      2,    3,    5,    0, 0, 0);
    add(0, 0, 0, 800, 440, 2,  1, ROUND_END, 2,    1,    6,    0, 0, 0);
    add(0, 0, 0, 800, 440, 0,  3, MATCH_END, 2,    1,    6,    0, 0, 1);
    add(0, 1, 0, 800, 440, 0,  2, MATCH_END, 2,    1,    6,    0, 0, 1);
    add(0, 0, 0, 800, 440, 0,  1, MATCH_END, 2,    1,    6,    0, 0, 1);
    add(0, 1, 0, 500, 640, 0,  2, START,     0,    0,    0,    0, 0, 0);
    add(0, 0, 0, 500, 640, 0,  1, START,     0,    0,    0,    0, 0, 0);
    add(0, 1, 0, 511, 440, 0,  2, COUNTDOWN, 1,    0,    0,    4, 0, 0);
    add(0, 0, 0, 511, 440, 0,  5, GAME,      1,    3,    0,    0, 0, 0);
    add(0, 0, 0, 511, 440, 1,  1, ROUND_END, 1,    2,    4,    0, 0, 0);
    add(0, 0, 0, 511, 440, 0,  8, GAME,      1,    3,    4,    0, 0, 0);
    add(1, 0, 0, 511, 440, 0,  1, START,     0,    0,    0,    0, 0, 0);
    add(0, 1, 0, 512, 440, 0,  2, COUNTDOWN, 2,    0,    0,    4, 0, 0);
    add(0, 0, 0, 512, 440, 0,  5, GAME,      2,    3,    0,    0, 0, 0);
`ifdef MATCH_FLOW_PAUSE_EN
    add(0, 0, 1, 512, 440, 0,  2, PAUSED,    2,    3,    0,    0, 0, 0);
    add(0, 0, 1, 512, 440, 1,  3, PAUSED,    2,    3,    0,    0, 0, 0);
    add(0, 0, 0, 512, 440, 1,  1, PAUSED,    2,    3,    0,    0, 0, 0);
    add(0, 0, 1, 512, 440, 0,  2, GAME,      2,    3,    0,    0, 0, 0);
    add(0, 0, 0, 512, 440, 0,  1, GAME,      2,    3,    0,    0, 0, 0);
    add(0, 0, 1, 512, 440, 0,  1, GAME,      2,    3,    0,    0, 0, 0);
    add(0, 0, 1, 512, 440, 1,  1, ROUND_END, 2,    2,    4,    0, 0, 0);
`endif

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; ml = vecs[k].ml; mr = vecs[k].mr;
      xpos = vecs[k].x; ypos = vecs[k].y; coll = vecs[k].coll;
      exp_q.push_back(vecs[k]);
      repeat (vecs[k].n) @(posedge clk);
      @(negedge clk);
      check_vec(exp_q.pop_front(), k);
    end

    // Edge-exact latency from a held press to GAME, then the ROUND_END hold length.
    rst = 1'b1; ml = 1'b0; mr = 1'b0; coll = '0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; ml = 1'b1; xpos = 12'd300; ypos = 12'd440;
    edges = 0;
    while (mode != GAME && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    check_val("game_latency", edges, CD + 2);
    check_val("join_strip0", int'(local_player), 1);
    ml = 1'b0; coll = 2'b11;
    @(posedge clk); @(negedge clk);
    coll = '0;
    check_val("draw_mode", int'(mode), int'(ROUND_END));
    check_val("draw_alive", int'(alive), 0);
    edges = 0;
    while (mode == ROUND_END && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    check_val("hold_len", edges, RH);
    check_val("after_hold", int'(mode), int'(COUNTDOWN));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
